// File: rtl/tlp_hdr_pkg.sv
// ============================================================================
// Module   : tlp_hdr_pkg
// Desc     : Shared codes, field offsets and completion-field helpers for the
//            TLP header router.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlp_hdr_pkg;

  localparam logic [4:0] TYPE_MEM  = 5'b00000;
  localparam logic [4:0] TYPE_IO   = 5'b00010;
  localparam logic [4:0] TYPE_CFG0 = 5'b00100;
  localparam logic [4:0] TYPE_CFG1 = 5'b00101;

  localparam logic [2:0] FMT_CPL  = 3'b000;
  localparam logic [2:0] FMT_CPLD = 3'b010;

  localparam logic [2:0] DEST_ERR = 3'd0;
  localparam logic [2:0] DEST_CFG = 3'd1;
  localparam logic [2:0] DEST_MEM = 3'd2;
  localparam logic [2:0] DEST_IO  = 3'd3;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  localparam int REQ_TYPE_LSB = 24;
  localparam int REQ_FMT_LSB  = 29;
  localparam int REQ_FBE_LSB  = 32;
  localparam int REQ_LBE_LSB  = 36;
  localparam int REQ_TAG_LSB  = 40;
  localparam int REQ_RID_LSB  = 48;

  localparam int CPL_FMT_LSB    = 29;
  localparam int CPL_BCNT_LSB   = 32;
  localparam int CPL_STATUS_LSB = 45;
  localparam int CPL_CID_LSB    = 48;
  localparam int CPL_LADDR_LSB  = 64;
  localparam int CPL_TAG_LSB    = 72;
  localparam int CPL_RID_LSB    = 80;

  typedef enum logic [2:0] {
    REQ_MRD = 3'd0,
    REQ_MWR = 3'd1,
    REQ_IO  = 3'd2,
    REQ_CFG = 3'd3,
    REQ_UR  = 3'd4
  } req_kind_t;

  function automatic req_kind_t classify(input logic [2:0] fmt, input logic [4:0] typ);
    classify = REQ_UR;
    if (typ == TYPE_MEM) begin
      if (fmt == 3'b000 || fmt == 3'b001) classify = REQ_MRD;
      else if (fmt == 3'b010 || fmt == 3'b011) classify = REQ_MWR;
    end else if (typ == TYPE_IO) begin
      classify = REQ_IO;
    end else if (typ == TYPE_CFG0 || typ == TYPE_CFG1) begin
      classify = REQ_CFG;
    end
  endfunction

  function automatic logic [1:0] be_lo(input logic [3:0] be);
    if (be[0])      be_lo = 2'd0;
    else if (be[1]) be_lo = 2'd1;
    else if (be[2]) be_lo = 2'd2;
    else if (be[3]) be_lo = 2'd3;
    else            be_lo = 2'd0;
  endfunction

  function automatic logic [1:0] be_hi(input logic [3:0] be);
    if (be[3])      be_hi = 2'd3;
    else if (be[2]) be_hi = 2'd2;
    else if (be[1]) be_hi = 2'd1;
    else            be_hi = 2'd0;
  endfunction

  // A length field of zero encodes 1024 DW; 4096 bytes wraps to 0 in 12 bits.
  function automatic logic [11:0] calc_byte_count(input logic [9:0] len,
                                                   input logic [3:0] fbe,
                                                   input logic [3:0] lbe);
    logic [12:0] dws4;
    logic [12:0] multi;
    logic [11:0] single;
    dws4   = (len == 10'd0) ? 13'd4096 : {1'b0, len, 2'b00};
    single = (fbe == 4'd0) ? 12'd1
                           : ({10'd0, be_hi(fbe)} - {10'd0, be_lo(fbe)} + 12'd1);
    multi  = dws4 - {11'd0, be_lo(fbe)} - (13'd3 - {11'd0, be_hi(lbe)});
    calc_byte_count = (len == 10'd1) ? single : multi[11:0];
  endfunction

  function automatic logic [6:0] calc_lower_addr(input logic       is64,
                                                 input logic [4:0] addr32,
                                                 input logic [4:0] addr64,
                                                 input logic [3:0] fbe);
    calc_lower_addr = {(is64 ? addr64 : addr32), be_lo(fbe)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hdr_fifo.sv
// ============================================================================
// Module   : hdr_fifo
// Desc     : Synchronous FIFO with registered count; head reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL_CNT = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]     c_CNT_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign full      = (r_count == c_FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/tlp_header_router.sv
// ============================================================================
// Module   : tlp_header_router
// Desc     : Classifies request TLPs, builds completion headers, queues them.
//            Define HDR_ROUTER_ERR_CNT_EN to add the err_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlp_header_router #(
  parameter int          PAYLOAD_WIDTH = 32,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] COMPLETER_ID  = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in_header,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [95:0]              out_header,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [2:0]               out_dest
`ifdef HDR_ROUTER_ERR_CNT_EN
  ,
  output logic [15:0]              err_count
`endif
);

  import tlp_hdr_pkg::*;

  localparam int c_ENTRY_W = 3 + PAYLOAD_WIDTH + 96;
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;

  req_kind_t              w_kind;
  logic [95:0]            w_cpl_hdr;
  logic [2:0]             w_dest;
  logic                   w_in_fire;
  logic                   w_s_drain;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [c_CNT_W-1:0]     w_fifo_count;
  logic [c_ENTRY_W-1:0]   w_head;
  logic                   w_unused_bits;

  logic                   r_s_valid;
  logic [c_ENTRY_W-1:0]   r_s_data;

  assign w_kind = classify(in_header[REQ_FMT_LSB +: 3], in_header[REQ_TYPE_LSB +: 5]);

  always_comb begin
    w_cpl_hdr = '0;
    w_dest    = DEST_ERR;
    w_cpl_hdr[CPL_TAG_LSB +: 8]  = in_header[REQ_TAG_LSB +: 8];
    w_cpl_hdr[CPL_RID_LSB +: 16] = in_header[REQ_RID_LSB +: 16];
    if (w_kind == REQ_UR) begin
      w_cpl_hdr[CPL_STATUS_LSB +: 3] = CPL_UR;
    end else begin
      w_cpl_hdr[9:0]                 = in_header[9:0];
      w_cpl_hdr[28:12]               = in_header[28:12];
      w_cpl_hdr[CPL_FMT_LSB +: 3]    = FMT_CPL;
      w_cpl_hdr[CPL_BCNT_LSB +: 12]  = 12'd4;
      w_cpl_hdr[CPL_STATUS_LSB +: 3] = CPL_SC;
      w_cpl_hdr[CPL_CID_LSB +: 16]   = COMPLETER_ID;
      case (w_kind)
        REQ_MRD: begin
          w_cpl_hdr[CPL_FMT_LSB +: 3]   = FMT_CPLD;
          w_cpl_hdr[CPL_BCNT_LSB +: 12] = calc_byte_count(in_header[9:0],
                                                          in_header[REQ_FBE_LSB +: 4],
                                                          in_header[REQ_LBE_LSB +: 4]);
          w_cpl_hdr[CPL_LADDR_LSB +: 7] = calc_lower_addr(in_header[29],
                                                          in_header[70:66],
                                                          in_header[102:98],
                                                          in_header[REQ_FBE_LSB +: 4]);
          w_dest = DEST_MEM;
        end
        REQ_MWR: w_dest = DEST_MEM;
        REQ_IO:  w_dest = DEST_IO;
        default: w_dest = DEST_CFG;
      endcase
    end
  end

  // Fullness is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = !r_s_valid || !w_fifo_full;
  assign w_in_fire = in_valid && in_ready;
  assign w_s_drain = r_s_valid && !w_fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else if (w_in_fire) begin
      r_s_valid <= 1'b1;
      r_s_data  <= {w_dest, in_payload, w_cpl_hdr};
    end else if (w_s_drain) begin
      r_s_valid <= 1'b0;
    end
  end

  hdr_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_s_drain),
    .push_data (r_s_data),
    .pop       (out_ready),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign out_valid = !w_fifo_empty;
  assign {out_dest, out_payload, out_header} = w_head;

`ifdef HDR_ROUTER_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 16'd0;
    end else if (w_in_fire && (w_kind == REQ_UR) && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign w_unused_bits = ^{in_header[127:103], in_header[97:71], in_header[65:64],
                           in_header[11:10], w_fifo_count};

endmodule

`default_nettype wire

// File: tb/tb_tlp_header_router.sv
// ============================================================================
// Module   : tb_tlp_header_router
// Desc     : Directed self-checking bench for tlp_header_router.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlp_header_router;

  localparam int PW    = 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_header;
  logic [PW-1:0]  in_payload;
  logic           out_valid;
  logic           out_ready;
  logic [95:0]    out_header;
  logic [PW-1:0]  out_payload;
  logic [2:0]     out_dest;
`ifdef HDR_ROUTER_ERR_CNT_EN
  logic [15:0]    err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tlp_header_router #(
    .PAYLOAD_WIDTH (PW),
    .FIFO_DEPTH    (DEPTH),
    .COMPLETER_ID  (16'hFFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_header   (in_header),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_header  (out_header),
    .out_payload (out_payload),
    .out_dest    (out_dest)
`ifdef HDR_ROUTER_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  function automatic logic [127:0] mk_hdr(input logic [2:0] fmt, input logic [4:0] typ,
                                          input logic [9:0] len, input logic [3:0] fbe,
                                          input logic [3:0] lbe, input logic [7:0] tag,
                                          input logic [15:0] rid, input logic [4:0] a32,
                                          input logic [4:0] a64);
    logic [127:0] h;
    h = '0;
    h[31:29] = fmt; h[28:24] = typ; h[9:0] = len;
    h[35:32] = fbe; h[39:36] = lbe; h[47:40] = tag; h[63:48] = rid;
    h[70:66] = a32; h[102:98] = a64;
    return h;
  endfunction

  function automatic logic [95:0] cpl(input logic [28:0] low, input logic [2:0] fmt,
                                      input logic [11:0] cnt, input logic [2:0] st,
                                      input logic [6:0] la, input logic [7:0] tag,
                                      input logic [15:0] rid, input logic [15:0] cid);
    return {rid, tag, 1'b0, la, cid, st, 1'b0, cnt, fmt, low};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] h, input logic [PW-1:0] p);
    bit done;
    done = 0;
    in_valid = 1'b1; in_header = h; in_payload = p;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL push_timeout: accepted=0 required=1"); end
  endtask

  task automatic pop_one(output logic [130:0] got);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (out_valid) seen = 1;
      else tick();
    end
    got = {out_dest, out_payload, out_header};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL pop_timeout: out_valid=0 required=1"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({in_ready, out_valid, out_dest, out_payload, out_header} !== {1'b1, 1'b0, 131'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h required rdy=1 vld=0 data=0",
               in_ready, out_valid, {out_dest, out_payload, out_header});
    end
`ifdef HDR_ROUTER_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL reset_err_count: got %h required 0", err_count); end
`endif
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL after_reset_handshake: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mem_read_1dw();
    logic [127:0] h;
    logic [130:0] got, exp;
    h = mk_hdr(3'b000, 5'b00000, 10'd1, 4'b0110, 4'b0000, 8'h5A, 16'hABCD, 5'b10101, 5'b00000);
    h[11:10] = 2'b11;
    exp = {3'd2, 32'hCAFE0001, cpl(29'd1, 3'b010, 12'd2, 3'b000, 7'h55, 8'h5A, 16'hABCD, 16'hFFFF)};
    push(h, 32'hCAFE0001);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrd1_latency_stage: out_valid=%b required 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrd1_latency_out: out_valid=%b required 1", out_valid); end
    pop_one(got);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL mrd1_entry: got %h required %h", got, exp); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrd1_drained: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_mem_read_multi();
    logic [130:0] got, exp;
    exp = {3'd2, 32'h0000BEEF, cpl(29'd4, 3'b010, 12'd12, 3'b000, 7'h0E, 8'h11, 16'h2222, 16'hFFFF)};
    push(mk_hdr(3'b001, 5'b00000, 10'd4, 4'b1100, 4'b0011, 8'h11, 16'h2222, 5'b11111, 5'b00011),
         32'h0000BEEF);
    pop_one(got);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL mrd_multi_entry: got %h required %h", got, exp); end
  endtask

  task automatic test_cfg_io_write();
    logic [130:0] got;
    push(mk_hdr(3'b010, 5'b00100, 10'd1, 4'b1111, 4'b0000, 8'h33, 16'h4444, 5'd0, 5'd0), 32'h1);
    push(mk_hdr(3'b000, 5'b00010, 10'd1, 4'b1111, 4'b0000, 8'h44, 16'h5555, 5'd0, 5'd0), 32'h2);
    push(mk_hdr(3'b011, 5'b00000, 10'd2, 4'b1111, 4'b1111, 8'h55, 16'h6666, 5'b11111, 5'd0), 32'h3);
    pop_one(got);
    n_cmp++;
    if (got !== {3'd1, 32'h1, cpl(29'h0400_0001, 3'b000, 12'd4, 3'b000, 7'h00, 8'h33, 16'h4444, 16'hFFFF)}) begin
      n_bad++; $display("FAIL cfg_entry: got %h", got);
    end
    pop_one(got);
    n_cmp++;
    if (got !== {3'd3, 32'h2, cpl(29'h0200_0001, 3'b000, 12'd4, 3'b000, 7'h00, 8'h44, 16'h5555, 16'hFFFF)}) begin
      n_bad++; $display("FAIL io_entry: got %h", got);
    end
    pop_one(got);
    n_cmp++;
    if (got !== {3'd2, 32'h3, cpl(29'd2, 3'b000, 12'd4, 3'b000, 7'h00, 8'h55, 16'h6666, 16'hFFFF)}) begin
      n_bad++; $display("FAIL mwr_entry: got %h", got);
    end
  endtask

  task automatic test_byte_count_edges();
    logic [130:0] got;
    push(mk_hdr(3'b000, 5'b00000, 10'd0, 4'b1111, 4'b1111, 8'h66, 16'h7777, 5'd0, 5'd0), 32'h10);
    pop_one(got);
    n_cmp++;
    if (got !== {3'd2, 32'h10, cpl(29'd0, 3'b010, 12'd0, 3'b000, 7'h00, 8'h66, 16'h7777, 16'hFFFF)}) begin
      n_bad++; $display("FAIL bcnt_len1024_wrap: got %h", got);
    end
    push(mk_hdr(3'b000, 5'b00000, 10'd1, 4'b0000, 4'b0000, 8'h67, 16'h7777, 5'b00001, 5'd0), 32'h11);
    pop_one(got);
    n_cmp++;
    if (got !== {3'd2, 32'h11, cpl(29'd1, 3'b010, 12'd1, 3'b000, 7'h04, 8'h67, 16'h7777, 16'hFFFF)}) begin
      n_bad++; $display("FAIL bcnt_fbe_zero: got %h", got);
    end
    push(mk_hdr(3'b000, 5'b00000, 10'd2, 4'b1000, 4'b0001, 8'h68, 16'h7777, 5'd0, 5'd0), 32'h12);
    pop_one(got);
    n_cmp++;
    if (got !== {3'd2, 32'h12, cpl(29'd2, 3'b010, 12'd2, 3'b000, 7'h03, 8'h68, 16'h7777, 16'hFFFF)}) begin
      n_bad++; $display("FAIL bcnt_2dw_partial: got %h", got);
    end
  endtask

  task automatic test_unsupported();
    logic [130:0] got;
`ifdef HDR_ROUTER_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL ur_err_count_before: got %h required 0", err_count); end
`endif
    push(mk_hdr(3'b000, 5'b11111, 10'd5, 4'b1111, 4'b1111, 8'h77, 16'h8888, 5'b11111, 5'd0), 32'h20);
`ifdef HDR_ROUTER_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd1) begin n_bad++; $display("FAIL ur_err_count_one: got %h required 1", err_count); end
`endif
    push(mk_hdr(3'b100, 5'b00000, 10'd1, 4'b1111, 4'b0000, 8'h78, 16'h9999, 5'd0, 5'd0), 32'h21);
`ifdef HDR_ROUTER_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd2) begin n_bad++; $display("FAIL ur_err_count_two: got %h required 2", err_count); end
`endif
    pop_one(got);
    n_cmp++;
    if (got !== {3'd0, 32'h20, cpl(29'd0, 3'b000, 12'd0, 3'b001, 7'h00, 8'h77, 16'h8888, 16'h0000)}) begin
      n_bad++; $display("FAIL ur_type_entry: got %h", got);
    end
    pop_one(got);
    n_cmp++;
    if (got !== {3'd0, 32'h21, cpl(29'd0, 3'b000, 12'd0, 3'b001, 7'h00, 8'h78, 16'h9999, 16'h0000)}) begin
      n_bad++; $display("FAIL ur_fmt_entry: got %h", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ep;
    out_ready = 1'b1;
    for (int k = 0; k <= DEPTH + 2; k++) begin
      if (k >= 2 && k <= DEPTH + 1) begin
        ep = 32'h100 + 32'(k - 2);
        n_cmp++;
        if ({out_valid, out_payload} !== {1'b1, ep}) begin
          n_bad++; $display("FAIL b2b_out_%0d: got vld=%b data=%h required vld=1 data=%h", k, out_valid, out_payload, ep);
        end
      end
      if (k < DEPTH) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready_%0d: got %b required 1", k, in_ready); end
        in_valid   = 1'b1;
        in_header  = mk_hdr(3'b010, 5'b00000, 10'd1, 4'b1111, 4'b0000, 8'(k), 16'h0101, 5'd0, 5'd0);
        in_payload = 32'h100 + 32'(k);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: out_valid=%b required 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepted;
    int got;
    accepted = 0;
    out_ready = 1'b0;
    in_header = mk_hdr(3'b010, 5'b00000, 10'd1, 4'b1111, 4'b0000, 8'h20, 16'h0202, 5'd0, 5'd0);
    for (int c = 0; c < 12 && accepted < DEPTH + 2; c++) begin
      in_valid   = 1'b1;
      in_payload = 32'h200 + 32'(accepted);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (accepted !== DEPTH + 1) begin n_bad++; $display("FAIL bp_accepted: got %0d required %0d", accepted, DEPTH + 1); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b required 0", in_ready); end
    tick(); tick();
    n_cmp++;
    if ({out_valid, out_payload} !== {1'b1, 32'h200}) begin
      n_bad++; $display("FAIL bp_head_stable: got vld=%b data=%h required vld=1 data=00000200", out_valid, out_payload);
    end
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        n_cmp++;
        if (out_payload !== 32'h200 + 32'(got)) begin
          n_bad++; $display("FAIL bp_order_%0d: got %h required %h", got, out_payload, 32'h200 + 32'(got));
        end
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (got !== DEPTH + 1) begin n_bad++; $display("FAIL bp_drain_count: got %0d required %0d", got, DEPTH + 1); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(mk_hdr(3'b010, 5'b00000, 10'd1, 4'b1111, 4'b0000, 8'(i), 16'h0303, 5'd0, 5'd0), 32'h300 + 32'(i));
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_queued: out_valid=%b required 1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_dest, out_payload, out_header} !== {1'b1, 1'b0, 131'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_immediate: got rdy=%b vld=%b data=%h required rdy=1 vld=0 data=0",
               in_ready, out_valid, {out_dest, out_payload, out_header});
    end
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_bad++; $display("FAIL rst_mid_stale_%0d: got rdy=%b vld=%b required 1 0", c, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_header = '0; in_payload = '0; out_ready = 1'b0;
    test_reset();
    test_mem_read_1dw();
    test_mem_read_multi();
    test_cfg_io_write();
    test_byte_count_edges();
    test_unsupported();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/tlp_header_router.md
# tlp_header_router

Parametrised successor to the single-link header sorter. Accepts a 128-bit PCIe request TLP header plus one payload word per transfer, classifies the request, builds the 96-bit completion header, and tags it with a destination subunit code. Results are queued in an output FIFO. Valid/ready handshakes on both sides replace the old "nonzero header means data" convention, so back-to-back streaming and back-pressure are lossless. Sits between the PCIe receive interface and the per-subunit ingress buffers.

## Interface
- `PAYLOAD_WIDTH`, 32: width of the pass-through payload word.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `COMPLETER_ID`, 16'hFFFF: value placed in completer ID field.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  request header/payload present.
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready`.
- `in_header`  in  128  request TLP header.
- `in_payload`  in  PAYLOAD_WIDTH  payload word accompanying header.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts; pop when `out_valid && out_ready`.
- `out_header`  out  96  completion header.
- `out_payload`  out  PAYLOAD_WIDTH  payload passed through unchanged.
- `out_dest`  out  3  destination: 0 error, 1 config, 2 memory, 3 I/O.
- `err_count`  out  16  unsupported-request count (only with `HDR_ROUTER_ERR_CNT_EN`).

## Operation
- Classification uses `T = hdr[28:24]` and `F = hdr[31:29]`:
  - Memory read: `T=00000`, `F∈{000,001}`, dest 2.
  - Memory write: `T=00000`, `F∈{010,011}`, dest 2.
  - I/O: `T=00010`, dest 3.
  - Config: `T∈{00100,00101}`, dest 1.
  - Anything else: dest 0.
- Completion header for all supported requests:
  - `[9:0]=hdr[9:0]`; `[11:10]=0`; `[28:12]=hdr[28:12]`.
  - `[31:29]=010` for memory read, `000` otherwise.
  - `[44]` BCM = 0; `[47:45]` status `000`; `[63:48]=COMPLETER_ID`; `[71]=0`.
  - `[79:72]=hdr[47:40]` (tag); `[95:80]=hdr[63:48]` (requester ID).
- Byte count `[43:32]`, 12 bits: 4 for write, I/O and config. For memory read, let `L` = length, where 0 means 1024. `FBE=hdr[35:32]`, `LBE=hdr[39:36]`.
  - `L=1`, `FBE=0`: count is 1.
  - `L=1`, `FBE≠0`: count is `hi(FBE)−lo(FBE)+1`.
  - `L>1`: count is `4L − lo(FBE) − (3−hi(LBE))`, truncated to 12 bits (4096 wraps to 0 per PCIe).
- Lower address `[70:64]`: 0 except memory read.
  - Memory read `[65:64]` = `lo(FBE)`, or 0 if `FBE=0`.
  - Memory read `[70:66]` = `hdr[70:66]` if `hdr[29]=0`, else `hdr[102:98]`.
- Unsupported: header all zero except status `[47:45]=001` (UR) and tag/requester fields still copied; dest 0.
- Pipeline: stage register S holds the translated entry. S drains into the FIFO when the FIFO is not full. `in_ready = !S_valid || !fifo_full`.
- FIFO fullness comes from the registered count; a same-cycle pop does not free a slot for a push.
- Output order equals acceptance order.

## Timing
- Reset values: `in_ready` 1 (combinational from empty state); `out_valid` 0; `out_header`, `out_payload`, `out_dest`, `err_count` 0; S and FIFO empty.
- Latency: accepted at edge N → in S after N → `out_valid` high after N+1 (2 cycles) when FIFO empty.
- Throughput: 1 transfer/cycle with `out_ready` held high.
- FIFO full with S valid: `in_ready` low. Deasserts the cycle after the FIFO reaches full while S is occupied.
- `out_valid` and output data stay stable while `out_ready` is low.
- FIFO pointers wrap modulo `FIFO_DEPTH`.
- Reset asserted mid-stream: all queued entries are discarded immediately; no partial output after release.

## Configuration
- `HDR_ROUTER_ERR_CNT_EN` defined: `err_count` port exists. It increments at S load of each unsupported request, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent. Unsupported requests are still emitted with UR status and dest 0.

## Structure
- Package `tlp_hdr_pkg` holds:
  - type/fmt codes;
  - destination codes (`DEST_ERR/CFG/MEM/IO`);
  - status codes (`CPL_SC=000`, `CPL_UR=001`);
  - field bit offsets;
  - byte-count and lower-address functions.
- Sub-module `hdr_fifo`: a synchronous FIFO parametrised by width and depth, exposing full, empty and count. The router instantiates it on `{dest, payload, header}`.

## Test plan
- **Memory read, 1 DW:** `F=000`, `T=0`, `L=1`, `FBE=0110`, `hdr[70:66]=10101`, tag 8'h5A, req 16'hABCD. Expect dest 2, fmt 010, count 2, lower addr 7'h55, status 000, tag/req copied, 2-cycle latency.
- **Memory read, multi-DW, 64-bit:** `F=001`, `L=4`, `FBE=1100`, `LBE=0011`, `hdr[102:98]=00011`. Expect count 12, lower addr 7'h0E.
- **Config and I/O:** `T=00100` → dest 1, count 4, fmt 000. `T=00010` → dest 3.
- **Unsupported:** `T=11111` → dest 0, status 001, count 0, fmt 000. `err_count` goes 0→1 when the macro is on.
- **Back-pressure:** `out_ready=0`, push `FIFO_DEPTH+2` requests. `in_ready` drops after `FIFO_DEPTH+1` accepted. Raise `out_ready` → all `FIFO_DEPTH+1` emerge in order, none lost or duplicated.
- **Reset mid-stream:** assert `rst` with 3 entries queued. Expect `out_valid` 0 at once; after release `in_ready` 1, with no stale output.
